// File: rtl/gf180mcu_ocd_io_brk_pkg.sv
// Shared definitions for the pad-ring supply-break controllers.
// Holds the controller state encoding and the default debounce/settle
// timings so sibling ring controllers stay consistent with this one.
package gf180mcu_ocd_io_brk_pkg;

    // Default timing, in clock cycles
    localparam int BRK_DEBOUNCE_CYCLES = 16;
    localparam int BRK_SETTLE_CYCLES   = 8;

    // Controller state encoding
    localparam int BRK_STATE_W = 3;

    localparam logic [BRK_STATE_W-1:0] ST_ISOLATED = 3'd0;
    localparam logic [BRK_STATE_W-1:0] ST_DEBOUNCE = 3'd1;
    localparam logic [BRK_STATE_W-1:0] ST_RELEASE  = 3'd2;
    localparam logic [BRK_STATE_W-1:0] ST_ACTIVE   = 3'd3;
    localparam logic [BRK_STATE_W-1:0] ST_DRAIN    = 3'd4;
    localparam logic [BRK_STATE_W-1:0] ST_FAULTED  = 3'd5;

endpackage

// File: rtl/gf180mcu_ocd_io__sync.sv
// Multi-flop synchronizer for a single asynchronous level input.
// All stages clear to 0 on reset, so a freshly reset segment always
// reads "no request / no supply" until the inputs propagate through.
module gf180mcu_ocd_io__sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // Shift the input through the synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            // NOTE: non-blocking assignment lets every stage sample the old value of the previous one, forming a real shift chain.
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_ocd_io__brk_ctl.sv
// Isolation-release controller for the far side of a pad-ring supply break.
// Waits for a synchronized power-up request plus a debounced local supply-good,
// releases the segment isolation clamps, then raises a four-phase acknowledge.
// Re-isolates on request withdrawal or supply loss.
//
// Build option: define GF180MCU_OCD_IO_BRK_FAULT_EN to make supply loss enter a
// sticky FAULTED state (FAULT=1, held until the request drops). Without it,
// supply loss drains like an orderly power-down and FAULT is tied low.
module gf180mcu_ocd_io__brk_ctl
    import gf180mcu_ocd_io_brk_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = BRK_DEBOUNCE_CYCLES,
    parameter int SETTLE_CYCLES   = BRK_SETTLE_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pwr_req,
    input  logic vdd_ok,
    output logic iso,
    output logic pwr_ack,
    output logic fault
);

    // Reject configurations the counters or synchronizers cannot support
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || SETTLE_CYCLES < 1 ||
        (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W) ||
        (SETTLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_param_err
        $error("gf180mcu_ocd_io__brk_ctl: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

`ifdef GF180MCU_OCD_IO_BRK_FAULT_EN
    localparam logic [BRK_STATE_W-1:0] LOSS_STATE = ST_FAULTED;
`else
    localparam logic [BRK_STATE_W-1:0] LOSS_STATE = ST_DRAIN;
`endif

    logic                   req_s;
    logic                   ok_s;
    logic [BRK_STATE_W-1:0] state_q;
    logic [BRK_STATE_W-1:0] state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   iso_d;
    logic                   ack_d;

    gf180mcu_ocd_io__sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (pwr_req),
        .q   (req_s)
    );

    gf180mcu_ocd_io__sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ok (
        .clk (clk),
        .rst (rst),
        .d   (vdd_ok),
        .q   (ok_s)
    );

    // Saturating increment: the counter never wraps back into a match
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // State, counter and registered pins; reset holds the clamps engaged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ISOLATED;
            cnt_q   <= '0;
            iso     <= 1'b1;
            pwr_ack <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iso     <= iso_d;
            pwr_ack <= ack_d;
        end
    end

    // Next-state and counter decode from the synchronized inputs
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ISOLATED: begin
                if (req_s && ok_s) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!(req_s && ok_s)) begin
                    state_d = ST_ISOLATED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (!ok_s) begin
                    state_d = LOSS_STATE;
                    cnt_d   = '0;
                end else if (!req_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q == SET_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ACTIVE: begin
                if (!ok_s) begin
                    state_d = LOSS_STATE;
                    cnt_d   = '0;
                end else if (!req_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                // Inputs are ignored until the settle time has elapsed
                if (cnt_q == SET_LAST) begin
                    state_d = ST_ISOLATED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`ifdef GF180MCU_OCD_IO_BRK_FAULT_EN
            ST_FAULTED: begin
                if (!req_s) begin
                    state_d = ST_ISOLATED;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = ST_ISOLATED;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values for the state being entered, registered on the same edge
    always_comb begin
        iso_d = 1'b1;
        ack_d = 1'b0;
        case (state_d)
            ST_RELEASE: iso_d = 1'b0;
            ST_ACTIVE: begin
                iso_d = 1'b0;
                ack_d = 1'b1;
            end
            // Acknowledge keeps whatever the requester last saw until drain ends
            ST_DRAIN: ack_d = pwr_ack;
            default: begin
                iso_d = 1'b1;
                ack_d = 1'b0;
            end
        endcase
    end

`ifdef GF180MCU_OCD_IO_BRK_FAULT_EN
    logic fault_d;

    // Sticky fault flag: set on entry to FAULTED, cleared on leaving it
    always_comb begin
        fault_d = (state_d == ST_FAULTED);
    end

    // Fault flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
        end else begin
            fault <= fault_d;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_ocd_io__brk_ctl.sv
// Self-checking bench for gf180mcu_ocd_io__brk_ctl (default parameters).
// A timestamp-based behavioural model predicts ISO/PWR_ACK/FAULT each cycle;
// directed sequences pin the model to hand-computed edge numbers, then a
// randomized phase toggles the inputs and pulses reset asynchronously.
module tb_gf180mcu_ocd_io__brk_ctl;
    import gf180mcu_ocd_io_brk_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = BRK_DEBOUNCE_CYCLES;
    localparam int SET  = BRK_SETTLE_CYCLES;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic pwr_req = 1'b0;
    logic vdd_ok  = 1'b0;
    logic iso;
    logic pwr_ack;
    logic fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf180mcu_ocd_io__brk_ctl #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .SETTLE_CYCLES   (SET),
        .CNT_W           (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pwr_req (pwr_req),
        .vdd_ok  (vdd_ok),
        .iso     (iso),
        .pwr_ack (pwr_ack),
        .fault   (fault)
    );

    // ---------------- behavioural model ----------------
    typedef enum logic [2:0] {P_OFF, P_QUAL, P_WAIT_ON, P_ON, P_DRAIN, P_FAULT} phase_t;

    typedef struct packed {
        int          cyc;        // edges since reset release
        int          t0;         // edge at which the current phase began
        phase_t      ph;
        logic        drain_ack;  // acknowledge level carried into a drain
        logic [15:0] hreq;       // input samples, bit i = sampled i edges ago
        logic [15:0] hok;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r    = '0;
        r.ph = P_OFF;
        return r;
    endfunction

    function automatic model_t model_step(model_t mi, logic req_in, logic ok_in);
        model_t n;
        logic   r;
        logic   o;
        logic   loss;
        logic   drain;
        n     = mi;
        loss  = 1'b0;
        drain = 1'b0;
        // What the controller sees now was sampled SYNC edges ago
        r      = mi.hreq[SYNC-1];
        o      = mi.hok[SYNC-1];
        n.hreq = {mi.hreq[14:0], req_in};
        n.hok  = {mi.hok[14:0], ok_in};
        n.cyc  = mi.cyc + 1;
        case (mi.ph)
            P_OFF: if (r && o) begin n.ph = P_QUAL; n.t0 = n.cyc; end
            P_QUAL: begin
                if (!(r && o)) n.ph = P_OFF;
                else if (n.cyc - n.t0 == DEB) begin n.ph = P_WAIT_ON; n.t0 = n.cyc; end
            end
            P_WAIT_ON: begin
                if (!o) loss = 1'b1;
                else if (!r) drain = 1'b1;
                else if (n.cyc - n.t0 == SET) n.ph = P_ON;
            end
            P_ON: begin
                if (!o) loss = 1'b1;
                else if (!r) drain = 1'b1;
            end
            P_DRAIN: if (n.cyc - n.t0 == SET) n.ph = P_OFF;
            P_FAULT: if (!r) n.ph = P_OFF;
            default: n.ph = P_OFF;
        endcase
        if (loss) begin
`ifdef GF180MCU_OCD_IO_BRK_FAULT_EN
            n.ph = P_FAULT;
`else
            drain = 1'b1;
`endif
        end
        if (drain) begin
            n.drain_ack = (mi.ph == P_ON);
            n.ph        = P_DRAIN;
            n.t0        = n.cyc;
        end
        return n;
    endfunction

    function automatic logic exp_iso(model_t x);
        return !(x.ph == P_WAIT_ON || x.ph == P_ON);
    endfunction

    function automatic logic exp_ack(model_t x);
        return (x.ph == P_ON) || (x.ph == P_DRAIN && x.drain_ack);
    endfunction

    function automatic logic exp_fault(model_t x);
        return x.ph == P_FAULT;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, pwr_req, vdd_ok);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, m.cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("cmp_iso",   iso,     exp_iso(m));
        check("cmp_ack",   pwr_ack, exp_ack(m));
        check("cmp_fault", fault,   exp_fault(m));
    end

    task automatic wait_cyc(input int n);
        int g;
        g = 0;
        while (m.cyc < n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (m.cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached cycle %0d, required %0d", m.cyc, n);
        end
    endtask

    // Reset, released on a falling edge so the next rising edge is edge 1
    task automatic do_reset();
        rst     = 1'b1;
        pwr_req = 1'b0;
        vdd_ok  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_iso",   iso,     1'b1);
        check("rst_ack",   pwr_ack, 1'b0);
        check("rst_fault", fault,   1'b0);
        rst = 1'b0;
    endtask

    task automatic power_up_checks(input string tag);
        wait_cyc(18); check({tag, "_iso_e18"}, iso, 1'b1);
        wait_cyc(19); check({tag, "_iso_e19"}, iso, 1'b0);
        check({tag, "_ack_e19"}, pwr_ack, 1'b0);
        wait_cyc(26); check({tag, "_ack_e26"}, pwr_ack, 1'b0);
        wait_cyc(27); check({tag, "_ack_e27"}, pwr_ack, 1'b1);
        check({tag, "_fault_e27"}, fault, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);

        // Power-up with defaults
        do_reset();
        pwr_req = 1'b1;
        vdd_ok  = 1'b1;
        power_up_checks("pwrup");

        // Debounce reject: one-cycle supply dip mid-debounce restarts the count
        do_reset();
        pwr_req = 1'b1;
        vdd_ok  = 1'b1;
        wait_cyc(11); vdd_ok = 1'b0;
        wait_cyc(12); vdd_ok = 1'b1;
        wait_cyc(19); check("deb_no_release_e19", iso, 1'b1);
        wait_cyc(30); check("deb_iso_e30", iso, 1'b1);
        wait_cyc(31); check("deb_iso_e31", iso, 1'b0);
        wait_cyc(39); check("deb_ack_e39", pwr_ack, 1'b1);

        // Orderly power-down, request re-raised during drain
        do_reset();
        pwr_req = 1'b1;
        vdd_ok  = 1'b1;
        wait_cyc(29); pwr_req = 1'b0;
        wait_cyc(31); check("down_iso_e31", iso, 1'b0);
        wait_cyc(32); check("down_iso_e32", iso, 1'b1);
        check("down_ack_e32", pwr_ack, 1'b1);
        wait_cyc(33); pwr_req = 1'b1;
        wait_cyc(39); check("down_ack_e39", pwr_ack, 1'b1);
        check("down_iso_e39", iso, 1'b1);
        wait_cyc(40); check("down_ack_e40", pwr_ack, 1'b0);
        wait_cyc(56); check("down_retry_iso_e56", iso, 1'b1);
        wait_cyc(57); check("down_retry_iso_e57", iso, 1'b0);

        // Supply loss while active
        do_reset();
        pwr_req = 1'b1;
        vdd_ok  = 1'b1;
        wait_cyc(29); vdd_ok = 1'b0;
        wait_cyc(31); check("loss_iso_e31", iso, 1'b0);
        wait_cyc(32); check("loss_iso_e32", iso, 1'b1);
`ifdef GF180MCU_OCD_IO_BRK_FAULT_EN
        check("loss_fault_e32", fault, 1'b1);
        check("loss_ack_e32", pwr_ack, 1'b0);
        wait_cyc(35); pwr_req = 1'b0;
        wait_cyc(37); check("loss_fault_e37", fault, 1'b1);
        wait_cyc(38); check("loss_fault_e38", fault, 1'b0);
        check("loss_iso_e38", iso, 1'b1);
`else
        check("loss_ack_e32", pwr_ack, 1'b1);
        check("loss_fault_e32", fault, 1'b0);
        wait_cyc(39); check("loss_ack_e39", pwr_ack, 1'b1);
        wait_cyc(40); check("loss_ack_e40", pwr_ack, 1'b0);
        check("loss_fault_e40", fault, 1'b0);
`endif

        // Asynchronous reset in RELEASE, then a full repeat of power-up
        do_reset();
        pwr_req = 1'b1;
        vdd_ok  = 1'b1;
        wait_cyc(22); check("arst_pre_iso", iso, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_iso_noclk", iso, 1'b1);
        check("arst_ack_noclk", pwr_ack, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        power_up_checks("arst_repeat");

        // Randomized inputs with occasional asynchronous reset pulses
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            if ($urandom_range(0, 99) < 2) pwr_req = ~pwr_req;
            if ($urandom_range(0, 99) < 2) vdd_ok  = ~vdd_ok;
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf180mcu_ocd_io__brk_ctl.md
# gf180mcu_ocd_io__brk_ctl

Isolation-release controller on the far side of a pad-ring supply break. A break cell splits the ring into independent VSS/VDD segments. This block receives the power-up request from the neighbouring segment and confirms the local supply with a debounce. It then releases the segment's isolation clamps and returns a four-phase acknowledge. It re-isolates the segment on request withdrawal or on loss of the local supply.

## Interface
- SYNC_STAGES, 2: synchronizer depth for PWR_REQ and VDD_OK (≥2).
- DEBOUNCE_CYCLES, 16: cycles both synced inputs must stay high before isolation is released (≥1).
- SETTLE_CYCLES, 8: cycles between isolation change and acknowledge change (≥1).
- CNT_W, 8: counter width; must hold max(DEBOUNCE_CYCLES, SETTLE_CYCLES)−1.
- CLK  input  1  single clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- PWR_REQ  input  1  power-up request from the neighbouring segment; asynchronous to CLK.
- VDD_OK  input  1  local supply-good detect; asynchronous to CLK.
- ISO  output  1  isolation enable, 1 = clamps engaged.
- PWR_ACK  output  1  four-phase acknowledge to the requester.
- FAULT  output  1  sticky supply-loss flag (see Configuration).

## Operation
- PWR_REQ and VDD_OK each pass through SYNC_STAGES flops, producing req_s and ok_s. The FSM sees only the synced values.
- All outputs are flop-driven and updated on the same edge as the state. There is no combinational decode to the pins.
- States: ISOLATED, DEBOUNCE, RELEASE, ACTIVE, DRAIN, FAULTED.
- ISOLATED (reset state): ISO=1, PWR_ACK=0. When req_s && ok_s, go to DEBOUNCE with cnt=0.
- DEBOUNCE: ISO=1, PWR_ACK=0.
  - If either synced input is low, go to ISOLATED. No partial credit is kept.
  - Otherwise, if cnt==DEBOUNCE_CYCLES−1, go to RELEASE with cnt=0; else cnt+1.
- RELEASE: ISO=0, PWR_ACK=0.
  - If ok_s is low, take the supply-loss path.
  - Else if req_s is low, go to DRAIN with cnt=0.
  - Else if cnt==SETTLE_CYCLES−1, go to ACTIVE; else cnt+1.
- ACTIVE: ISO=0, PWR_ACK=1.
  - If ok_s is low, take the supply-loss path.
  - Else if req_s is low, go to DRAIN with cnt=0.
- DRAIN: ISO=1, PWR_ACK holds its value from the previous state.
  - After SETTLE_CYCLES cycles, go to ISOLATED with PWR_ACK=0.
  - A req_s re-rise during DRAIN is ignored until ISOLATED is reached.
- Supply-loss path: ISO=1 on the next edge. Behaviour depends on the macro (see Configuration).
- Simultaneous req_s fall and ok_s fall: supply loss has priority.
- Counters saturate and are never compared across a wrap. CNT_W too small is a parameter error.
- Reset is asynchronous: ISO=1, PWR_ACK=0, FAULT=0, state=ISOLATED, cnt=0, all sync flops cleared. It takes effect immediately, mid-operation included. ISO must never glitch low during or after reset.

## Timing
- Reset values: ISO=1, PWR_ACK=0, FAULT=0.
- Both inputs rise and stay high before edge 1:
  - FSM enters DEBOUNCE at edge SYNC_STAGES+1.
  - ISO falls after edge SYNC_STAGES+1+DEBOUNCE_CYCLES (defaults: edge 19).
  - PWR_ACK rises SETTLE_CYCLES edges later (defaults: edge 27).
- PWR_REQ falls while ACTIVE before edge n:
  - ISO=1 after edge n+SYNC_STAGES.
  - PWR_ACK=0 after edge n+SYNC_STAGES+SETTLE_CYCLES.
- VDD_OK falls while ACTIVE before edge n: ISO=1 after edge n+SYNC_STAGES.
- Handshake: PWR_ACK rises only after ISO is low, and falls only after ISO is high. The requester must not re-raise PWR_REQ until PWR_ACK is low.

## Configuration
- Macro: GF180MCU_OCD_IO_BRK_FAULT_EN.
- Defined: supply loss goes to FAULTED with ISO=1, PWR_ACK=0, FAULT=1.
  - FAULTED persists while req_s is high.
  - On req_s low, go to ISOLATED and clear FAULT on that edge.
- Undefined: supply loss goes to DRAIN (ISO=1, PWR_ACK drops after SETTLE_CYCLES). FAULT is tied 0 and FAULTED is not built.

## Structure
- Shared package gf180mcu_ocd_io_brk_pkg holds:
  - the state encoding localparams;
  - the default DEBOUNCE_CYCLES and SETTLE_CYCLES values, for reuse by sibling ring controllers.
- One sub-module, gf180mcu_ocd_io__sync, a parameterized SYNC_STAGES-deep synchronizer with async reset to 0. It is instantiated twice.

## Test plan
- Power-up, defaults: assert PWR_REQ=VDD_OK=1 after reset → ISO falls after edge 19, PWR_ACK rises after edge 27, FAULT=0.
- Debounce reject: VDD_OK pulses low for 1 cycle at DEBOUNCE count 10 → return to ISOLATED. On a stable retry, ISO falls a full 16 debounce cycles after re-entry.
- Orderly power-down: drop PWR_REQ in ACTIVE at edge n → ISO=1 after n+2, PWR_ACK=0 after n+10. A PWR_REQ re-rise during DRAIN is ignored.
- Supply loss, macro defined: drop VDD_OK in ACTIVE → ISO=1 and FAULT=1 after 2 edges, PWR_ACK=0. FAULT holds until PWR_REQ drops, then clears.
- Supply loss, macro undefined: same stimulus → ISO=1 after 2 edges, PWR_ACK=0 8 edges later, FAULT stays 0.
- Async reset mid-RELEASE: assert RST between clock edges → ISO=1, PWR_ACK=0 without a clock. After release of reset, a full power-up sequence repeats with 19/27 latency.
